// File: rtl/trng_sampler.sv
// trng_sampler: consumer end of the ring-oscillator entropy source.
//
// Synchronizes the free-running RO bit and samples it once every SAMPLE_DIV clocks. A von Neumann
// corrector removes bias: it takes raw samples in pairs, maps 10 to 1 and 01 to 0, and discards
// 00 and 11. Corrected bits are packed MSB-first into WORD_WIDTH-bit words. Each word is offered
// on a valid/ready interface. A repetition-count health test watches the raw samples. When it
// trips, it latches a sticky failure flag and stops collection until reset.
//
// Ports:
//   clk          single clock
//   rst          synchronous, active-high reset
//   raw_bit      asynchronous entropy bit from the RO combiner
//   enable       run sampling/collection; low returns to idle and drops partial words
//   data_out     assembled random word
//   data_valid   data_out holds an untaken word
//   data_ready   downstream accepts the word (transfer when data_valid && data_ready)
//   health_fail  sticky repetition-count failure, cleared only by rst
module trng_sampler #(
    parameter int unsigned WORD_WIDTH  = 32,
    parameter int unsigned SAMPLE_DIV  = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned REP_LIMIT   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  raw_bit,
    input  logic                  enable,
    output logic [WORD_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  health_fail
);

    localparam int unsigned DivW    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned RepW    = $clog2(REP_LIMIT + 1);
    localparam int unsigned BitCntW = $clog2(WORD_WIDTH + 1);

    localparam logic [DivW-1:0]    DivLast = DivW'(SAMPLE_DIV - 1);
    localparam logic [RepW-1:0]    RepMax  = RepW'(REP_LIMIT);
    localparam logic [BitCntW-1:0] BitFull = BitCntW'(WORD_WIDTH);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StFail    = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic [DivW-1:0]         div_cnt_q, div_cnt_d;
    logic [RepW-1:0]         rep_cnt_q, rep_cnt_d;
    logic                    last_sample_q, last_sample_d;
    logic                    have_first_q, have_first_d;
    logic                    first_q, first_d;
    logic [WORD_WIDTH-1:0]   acc_q, acc_d;
    logic [BitCntW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [WORD_WIDTH-1:0]   data_out_q, data_out_d;
    logic                    data_valid_q, data_valid_d;
    logic                    health_fail_q, health_fail_d;

    logic                    s_bit;
    logic                    active;
    logic                    strobe;
    logic                    xfer;
    logic                    emit;
    logic                    emit_bit;
    logic                    out_free;
    logic [WORD_WIDTH-1:0]   acc_n;
    logic [BitCntW-1:0]      cnt_n;
    logic [RepW-1:0]         rep_n;

    assign s_bit  = sync_q[SYNC_STAGES-1];
    assign xfer   = data_valid_q && data_ready;
    assign active = enable && (state_q != StFail);
    assign strobe = active && (div_cnt_q == DivLast);

    always_comb begin
        state_d       = state_q;
        sync_d        = {sync_q[SYNC_STAGES-2:0], raw_bit};
        div_cnt_d     = div_cnt_q;
        rep_cnt_d     = rep_cnt_q;
        last_sample_d = last_sample_q;
        have_first_d  = have_first_q;
        first_d       = first_q;
        acc_d         = acc_q;
        bit_cnt_d     = bit_cnt_q;
        data_out_d    = data_out_q;
        data_valid_d  = data_valid_q;
        health_fail_d = health_fail_q;
        emit          = 1'b0;
        emit_bit      = 1'b0;
        out_free      = !data_valid_q || xfer;
        acc_n         = acc_q;
        cnt_n         = bit_cnt_q;
        rep_n         = rep_cnt_q;

        if (xfer) begin
            data_valid_d = 1'b0;
        end

        if (!active) begin
            // Idle or failed: drop any partial (or held) word; only the output register survives.
            div_cnt_d    = '0;
            have_first_d = 1'b0;
            acc_d        = '0;
            bit_cnt_d    = '0;
            if (state_q != StFail) begin
                state_d       = StIdle;
                rep_cnt_d     = '0;   // zero marks "no sample yet" for the health test
                last_sample_d = 1'b0;
            end
        end else begin
            state_d   = StCollect;
            div_cnt_d = strobe ? '0 : div_cnt_q + DivW'(1);

            if (strobe) begin
                if (rep_cnt_q != '0 && s_bit == last_sample_q) begin
                    rep_n = (rep_cnt_q == RepMax) ? RepMax : rep_cnt_q + RepW'(1);
                end else begin
                    rep_n = RepW'(1);
                end
                rep_cnt_d     = rep_n;
                last_sample_d = s_bit;

                if (rep_n == RepMax) begin
                    // The tripping sample is never used as corrector input.
                    health_fail_d = 1'b1;
                    state_d       = StFail;
                    have_first_d  = 1'b0;
                end else if (!have_first_q) begin
                    first_d      = s_bit;
                    have_first_d = 1'b1;
                end else begin
                    have_first_d = 1'b0;
                    if (first_q != s_bit) begin
                        emit     = 1'b1;
                        emit_bit = first_q;
                    end
                end
            end

            // A word held full behind a busy output moves out first, then the new bit starts
            // the next word.
            if (cnt_n == BitFull && out_free) begin
                data_out_d   = acc_n;
                data_valid_d = 1'b1;
                out_free     = 1'b0;
                acc_n        = '0;
                cnt_n        = '0;
            end
            // While full and blocked, new bits are dropped rather than shifted in.
            if (emit && cnt_n != BitFull) begin
                acc_n = {acc_n[WORD_WIDTH-2:0], emit_bit};
                cnt_n = cnt_n + BitCntW'(1);
            end
            if (cnt_n == BitFull && out_free) begin
                data_out_d   = acc_n;
                data_valid_d = 1'b1;
                acc_n        = '0;
                cnt_n        = '0;
            end
            acc_d     = acc_n;
            bit_cnt_d = cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            sync_q        <= '0;
            div_cnt_q     <= '0;
            rep_cnt_q     <= '0;
            last_sample_q <= 1'b0;
            have_first_q  <= 1'b0;
            first_q       <= 1'b0;
            acc_q         <= '0;
            bit_cnt_q     <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            health_fail_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            div_cnt_q     <= div_cnt_d;
            rep_cnt_q     <= rep_cnt_d;
            last_sample_q <= last_sample_d;
            have_first_q  <= have_first_d;
            first_q       <= first_d;
            acc_q         <= acc_d;
            bit_cnt_q     <= bit_cnt_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            health_fail_q <= health_fail_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign health_fail = health_fail_q;

endmodule

// File: tb/tb_trng_sampler.sv
// Testbench for trng_sampler: directed scenarios with literal expectations, then randomized
// stimulus. A behavioural model built from raw-sample history, a bit queue and the output
// word checks every cycle.
module tb_trng_sampler;

    localparam int W    = 8;
    localparam int DIV  = 1;
    localparam int SYNC = 2;
    localparam int REP  = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         raw_bit;
    logic         enable;
    logic         data_ready;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         health_fail;

    always #5 clk = ~clk;

    trng_sampler #(
        .WORD_WIDTH (W),
        .SAMPLE_DIV (DIV),
        .SYNC_STAGES(SYNC),
        .REP_LIMIT  (REP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .raw_bit    (raw_bit),
        .enable     (enable),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .health_fail(health_fail)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit checking    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit           m_sync[$];     // raw samples in flight through the synchronizer
    int           m_en_cycles;   // enabled cycles since enable rose
    bit           m_fail;
    bit           m_last;
    int           m_run;         // length of current run of equal samples (0 = none yet)
    bit           m_have;
    bit           m_first;
    bit           m_bits[$];     // corrected bits of the word being built, oldest first
    logic [W-1:0] m_out;
    bit           m_valid;

    function automatic logic [W-1:0] pack_word();
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[W-1-i] = m_bits[i];
        return v;
    endfunction

    task automatic model_step();
        bit s, xfer, free, emit, eb;
        s = m_sync[0];
        m_sync.push_back(raw_bit);
        void'(m_sync.pop_front());
        if (rst) begin
            m_sync.delete();
            for (int i = 0; i < SYNC; i++) m_sync.push_back(1'b0);
            m_en_cycles = 0; m_fail = 0; m_last = 0; m_run = 0;
            m_have = 0; m_first = 0; m_bits.delete(); m_out = '0; m_valid = 0;
        end else begin
            xfer = m_valid && data_ready;
            free = !m_valid || xfer;
            if (xfer) m_valid = 0;
            emit = 0;
            eb   = 0;
            if (!enable || m_fail) begin
                m_en_cycles = 0;
                m_have      = 0;
                m_bits.delete();
                if (!m_fail) m_run = 0;
            end else begin
                m_en_cycles++;
                if (m_en_cycles % DIV == 0) begin
                    m_run  = (m_run > 0 && s == m_last) ? m_run + 1 : 1;
                    m_last = s;
                    if (m_run >= REP) m_fail = 1;
                    else if (!m_have) begin
                        m_have = 1; m_first = s;
                    end else begin
                        m_have = 0;
                        if (m_first != s) begin emit = 1; eb = m_first; end
                    end
                end
                if (m_bits.size() == W && free) begin
                    m_out = pack_word(); m_valid = 1; m_bits.delete(); free = 0;
                end
                if (emit && m_bits.size() < W) m_bits.push_back(eb);
                if (m_bits.size() == W && free) begin
                    m_out = pack_word(); m_valid = 1; m_bits.delete();
                end
            end
        end
    endtask

    always @(posedge clk) model_step();

    // ---------------- per-cycle compare + observation ----------------
    logic [W-1:0] got[$];
    bit           prev_valid  = 0;
    int           rise_cyc    = 0;
    int           valid_cycles = 0;

    always @(negedge clk) begin
        if (checking) begin
            check("data_valid", data_valid, m_valid);
            check("health_fail", health_fail, m_fail);
            check("data_out", data_out, m_out);
            if (data_valid && data_ready) got.push_back(data_out);
            if (data_valid && !prev_valid) rise_cyc = cyc;
            if (data_valid) valid_cycles++;
            prev_valid = data_valid;
        end
    end

    // ---------------- stimulus helpers ----------------
    bit stim[$];
    int fph = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) begin
            stim.push_back(w[i]);
            stim.push_back(!w[i]);
        end
    endtask

    task automatic add_pair(input bit a, input bit b);
        stim.push_back(a);
        stim.push_back(b);
    endtask

    // Raw bits lead enable by SYNC cycles so the first strobe samples stim[0].
    task automatic play();
        for (int c = 0; c < stim.size(); c++) begin
            raw_bit = stim[c];
            if (c >= SYNC) enable = 1'b1;
            tick();
        end
        stim.delete();
        fph = 0;
    endtask

    // 1100 pattern: pairs 11/00 only, runs of 2, never emits or trips.
    task automatic filler(input int n);
        for (int i = 0; i < n; i++) begin
            raw_bit = (fph % 4) < 2;
            fph++;
            tick();
        end
    endtask

    int start;

    initial begin
        rst = 1'b1; enable = 1'b0; raw_bit = 1'b0; data_ready = 1'b0;
        tick();
        checking = 1;
        data_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("reset data_valid", data_valid, 0);
        check("reset data_out", data_out, 0);
        check("reset health_fail", health_fail, 0);
        tick(); tick();
        check("reset no transfer", got.size(), 0);

        // Corrector mapping
        got.delete(); valid_cycles = 0;
        add_word(8'b10110010);
        start = cyc;
        play(); filler(8); enable = 1'b0; tick(); tick();
        check("map words", got.size(), 1);
        if (got.size() > 0) check("map value", got[0], 8'hB2);
        check("map valid cycles", valid_cycles, 1);
        check("map latency", rise_cyc - start, 18);

        // Equal pairs discarded
        got.delete();
        add_pair(1, 0); add_pair(0, 0); add_pair(0, 1); add_pair(1, 0); add_pair(1, 0);
        add_pair(1, 1); add_pair(0, 1); add_pair(0, 1); add_pair(1, 0); add_pair(0, 1);
        start = cyc;
        play(); filler(8); enable = 1'b0; tick(); tick();
        check("discard words", got.size(), 1);
        if (got.size() > 0) check("discard value", got[0], 8'hB2);
        check("discard latency", rise_cyc - start, 22);

        // Backpressure: two full words, extra bits dropped
        got.delete(); data_ready = 1'b0;
        for (int i = 0; i < 18; i++) add_pair(1, 0);
        play(); filler(8);
        check("bp held valid", data_valid, 1);
        check("bp held data", data_out, 8'hFF);
        data_ready = 1'b1; filler(1); data_ready = 1'b0; filler(4);
        check("bp second valid", data_valid, 1);
        check("bp second data", data_out, 8'hFF);
        check("bp first taken", got.size(), 1);
        data_ready = 1'b1; filler(1); data_ready = 1'b0; filler(4);
        check("bp drained", data_valid, 0);
        check("bp words", got.size(), 2);
        enable = 1'b0; tick(); tick();

        // Health test with a pending word
        got.delete();
        for (int i = 0; i < 8; i++) add_pair(1, 0);
        for (int i = 0; i < 4; i++) add_pair(1, 1);
        play(); filler(8);
        check("hf set", health_fail, 1);
        check("hf pending valid", data_valid, 1);
        check("hf pending data", data_out, 8'hFF);
        data_ready = 1'b1; filler(1); data_ready = 1'b0;
        check("hf pending taken", got.size(), 1);
        for (int i = 0; i < 8; i++) add_pair(1, 0);
        play(); filler(8);
        check("hf no new word", data_valid, 0);
        enable = 1'b0; tick(); tick(); tick();
        check("hf sticky", health_fail, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("hf cleared by rst", health_fail, 0);

        // Enable drop mid-word discards partial bits
        got.delete(); data_ready = 1'b1;
        for (int i = 0; i < 5; i++) add_pair(1, 0);
        play(); filler(4); enable = 1'b0; tick(); tick(); tick();
        add_word(8'h5A);
        play(); filler(8); enable = 1'b0; tick(); tick();
        check("reenable words", got.size(), 1);
        if (got.size() > 0) check("reenable value", got[0], 8'h5A);

        // Reset while a word is pending
        data_ready = 1'b0;
        add_word(8'hA5);
        play(); filler(8);
        check("pre-rst valid", data_valid, 1);
        check("pre-rst data", data_out, 8'hA5);
        rst = 1'b1; tick(); rst = 1'b0; enable = 1'b0;
        check("rst drops valid", data_valid, 0);
        check("rst clears data", data_out, 0);
        tick();

        // Randomized phase
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) < 6) raw_bit = 1'($urandom_range(0, 1));
            if (enable) begin
                if ($urandom_range(0, 59) == 0) enable = 1'b0;
            end else if ($urandom_range(0, 4) == 0) begin
                enable = 1'b1;
            end
            data_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0; enable = 1'b0; tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
